parking_gate_arbiter: RTL and testbench

- Owns the single barrier gate shared by the entry lane and the exit lane of the parking lot.
- Arbitrates between the two lane requests using the parking FSM's capacity and occupancy status.
- Sequences the gate motor through open, hold and close.
- Issues one-cycle completion pulses that drive the parking FSM's entry_signal, exit_signal and exit_slot inputs.

---
 rtl/parking_gate_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_parking_gate_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter.sv
// Barrier gate shared by the entry and exit lanes: qualifies and arbitrates lane
// requests, runs the motor through open/hold/close and pulses completion strobes.
module parking_gate_arbiter #(
  parameter int OPEN_CYCLES  = 3,
  parameter int HOLD_CYCLES  = 5,
  parameter int CLOSE_CYCLES = 3,
  parameter int TIMER_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_slot,
  input  logic [2:0] capacity,
  input  logic [3:0] spots,
  input  logic       pass_sensor,
  input  logic       obstruct,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic [1:0] ack_slot,
  output logic       entry_reject,
  output logic       exit_reject,
  output logic       motor_up,
  output logic       motor_down,
  output logic       gate_open,
  output logic [1:0] grant_owner,
  output logic       timeout
);

  typedef enum logic [1:0] {S_IDLE, S_OPENING, S_OPEN, S_CLOSING} state_t;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_ENTRY = 2'b01;
  localparam logic [1:0] OWN_EXIT  = 2'b10;

  localparam logic [TIMER_W-1:0] OPEN_LD  = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LD  = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CLOSE_LD = TIMER_W'(CLOSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CNT_ONE  = TIMER_W'(1);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               entry_lock_q, entry_lock_d;
  logic               exit_lock_q, exit_lock_d;
  logic               last_entry_q, last_entry_d;
  logic               acked_q, acked_d;
  logic [1:0]         ack_slot_q, ack_slot_d;
  logic [1:0]         owner_q, owner_d;
  logic               entry_ack_q, entry_ack_d;
  logic               exit_ack_q, exit_ack_d;
  logic               entry_rej_q, entry_rej_d;
  logic               exit_rej_q, exit_rej_d;
  logic               motor_up_q, motor_up_d;
  logic               motor_down_q, motor_down_d;
  logic               gate_open_q, gate_open_d;
  logic               timeout_q, timeout_d;
  logic               entry_valid, exit_valid;

  assign entry_valid = entry_req && (capacity != 3'd0) && !entry_lock_q;
  assign exit_valid  = exit_req && spots[exit_slot] && !exit_lock_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    entry_lock_d = entry_lock_q;
    exit_lock_d  = exit_lock_q;
    last_entry_d = last_entry_q;
    acked_d      = acked_q;
    ack_slot_d   = ack_slot_q;
    owner_d      = owner_q;
    entry_ack_d  = 1'b0;
    exit_ack_d   = 1'b0;
    entry_rej_d  = 1'b0;
    exit_rej_d   = 1'b0;
    timeout_d    = 1'b0;

    // A lock re-arms its lane once the request has been seen low.
    if (!entry_req) entry_lock_d = 1'b0;
    if (!exit_req)  exit_lock_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (entry_req && (capacity == 3'd0) && !entry_lock_q) begin
          entry_rej_d  = 1'b1;
          entry_lock_d = 1'b1;
        end
        if (exit_req && !spots[exit_slot] && !exit_lock_q) begin
          exit_rej_d  = 1'b1;
          exit_lock_d = 1'b1;
        end
        if (exit_valid || entry_valid) begin
          // last_entry_q=1 hands a tie to the exit lane.
          if (exit_valid && (!entry_valid || last_entry_q)) begin
            owner_d      = OWN_EXIT;
            last_entry_d = 1'b0;
          end else begin
            owner_d      = OWN_ENTRY;
            last_entry_d = 1'b1;
          end
          state_d    = S_OPENING;
          cnt_d      = OPEN_LD;
          ack_slot_d = exit_slot;
          acked_d    = 1'b0;
        end
      end
      S_OPENING: begin
        if (cnt_q == '0) begin
          state_d = S_OPEN;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_OPEN: begin
        if (pass_sensor) begin
          state_d = S_CLOSING;
          cnt_d   = CLOSE_LD;
          if (!acked_q) begin
            acked_d     = 1'b1;
            entry_ack_d = (owner_q == OWN_ENTRY);
            exit_ack_d  = (owner_q == OWN_EXIT);
          end
        end else if (cnt_q == '0) begin
          state_d   = S_CLOSING;
          cnt_d     = CLOSE_LD;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_CLOSING: begin
        if (obstruct) begin
          state_d = S_OPENING;
          cnt_d   = OPEN_LD;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    motor_up_d   = (state_d == S_OPENING);
    motor_down_d = (state_d == S_CLOSING);
    gate_open_d  = (state_d == S_OPEN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      entry_lock_q <= 1'b0;
      exit_lock_q  <= 1'b0;
      last_entry_q <= 1'b1;
      acked_q      <= 1'b0;
      ack_slot_q   <= 2'b00;
      owner_q      <= OWN_NONE;
      entry_ack_q  <= 1'b0;
      exit_ack_q   <= 1'b0;
      entry_rej_q  <= 1'b0;
      exit_rej_q   <= 1'b0;
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
      gate_open_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      entry_lock_q <= entry_lock_d;
      exit_lock_q  <= exit_lock_d;
      last_entry_q <= last_entry_d;
      acked_q      <= acked_d;
      ack_slot_q   <= ack_slot_d;
      owner_q      <= owner_d;
      entry_ack_q  <= entry_ack_d;
      exit_ack_q   <= exit_ack_d;
      entry_rej_q  <= entry_rej_d;
      exit_rej_q   <= exit_rej_d;
      motor_up_q   <= motor_up_d;
      motor_down_q <= motor_down_d;
      gate_open_q  <= gate_open_d;
      timeout_q    <= timeout_d;
    end
  end

  assign entry_ack    = entry_ack_q;
  assign exit_ack     = exit_ack_q;
  assign ack_slot     = ack_slot_q;
  assign entry_reject = entry_rej_q;
  assign exit_reject  = exit_rej_q;
  assign motor_up     = motor_up_q;
  assign motor_down   = motor_down_q;
  assign gate_open    = gate_open_q;
  assign grant_owner  = owner_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Cycle-accurate scoreboard bench for parking_gate_arbiter: each driven cycle
// queues the full output word expected after the next rising edge.
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_req, exit_req, pass_sensor, obstruct;
  logic [1:0] exit_slot;
  logic [2:0] capacity;
  logic [3:0] spots;
  logic       entry_ack, exit_ack, entry_reject, exit_reject;
  logic       motor_up, motor_down, gate_open, timeout;
  logic [1:0] ack_slot, grant_owner;

  logic [11:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Output word: [11]entry_ack [10]exit_ack [9:8]slot [7]entry_rej [6]exit_rej
  // [5]up [4]down [3]open [2:1]owner [0]timeout. Slot only counts with exit_ack.
  localparam logic [11:0] W_IDLE = 12'h000;
  localparam logic [11:0] W_EA   = 12'h800;
  localparam logic [11:0] W_XA   = 12'h400;
  localparam logic [11:0] W_ER   = 12'h080;
  localparam logic [11:0] W_XR   = 12'h040;
  localparam logic [11:0] W_TO   = 12'h001;
  localparam int          HOLD   = 5;

  logic [11:0] obs_w;
  assign obs_w = {entry_ack, exit_ack, (exit_ack ? ack_slot : 2'b00), entry_reject,
                  exit_reject, motor_up, motor_down, gate_open, grant_owner, timeout};

  parking_gate_arbiter dut (
    .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
    .exit_slot(exit_slot), .capacity(capacity), .spots(spots),
    .pass_sensor(pass_sensor), .obstruct(obstruct), .entry_ack(entry_ack),
    .exit_ack(exit_ack), .ack_slot(ack_slot), .entry_reject(entry_reject),
    .exit_reject(exit_reject), .motor_up(motor_up), .motor_down(motor_down),
    .gate_open(gate_open), .grant_owner(grant_owner), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) check_eq(tag_q.pop_front(), obs_w, exp_q.pop_front());
  end

  function automatic logic [11:0] w_phase(input logic [1:0] own, input logic up,
                                          input logic dn, input logic op);
    return {6'b000000, up, dn, op, own, 1'b0};
  endfunction

  // One clock: inputs are already set; queue the word expected after the edge.
  task automatic cyc(input string tag, input logic [11:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    #1;
  endtask

  // Remaining two OPENING cycles plus the first OPEN cycle.
  task automatic up_to_open(input logic [1:0] own, input logic noise);
    pass_sensor = noise;
    obstruct    = noise;
    cyc("opening", w_phase(own, 1'b1, 1'b0, 1'b0));
    cyc("opening", w_phase(own, 1'b1, 1'b0, 1'b0));
    cyc("open1", w_phase(own, 1'b0, 1'b0, 1'b1));
    pass_sensor = 1'b0;
    obstruct    = 1'b0;
  endtask

  // Open-hold phase; pass_at is the OPEN cycle carrying pass_sensor (0 = none).
  task automatic hold(input logic [1:0] own, input logic [1:0] slot, input int pass_at,
                      input logic give_ack);
    logic [11:0] e;
    for (int k = 1; k <= HOLD; k++) begin
      pass_sensor = (k == pass_at);
      if (k == pass_at) begin
        e = w_phase(own, 1'b0, 1'b1, 1'b0);
        if (give_ack && own == 2'b01) e = e | W_EA;
        if (give_ack && own == 2'b10) e = e | W_XA | {2'b00, slot, 8'h00};
        cyc("ack_close", e);
        break;
      end else if (k == HOLD) begin
        cyc("timeout", w_phase(own, 1'b0, 1'b1, 1'b0) | W_TO);
      end else begin
        cyc("hold", w_phase(own, 1'b0, 1'b0, 1'b1));
      end
    end
    pass_sensor = 1'b0;
  endtask

  task automatic close_tail(input logic [1:0] own);
    cyc("closing", w_phase(own, 1'b0, 1'b1, 1'b0));
    cyc("closing", w_phase(own, 1'b0, 1'b1, 1'b0));
    cyc("idle_ret", W_IDLE);
  endtask

  initial begin
    reset = 1'b1; entry_req = 1'b1; exit_req = 1'b0; pass_sensor = 1'b0; obstruct = 1'b0;
    exit_slot = 2'd0; capacity = 3'd4; spots = 4'b0000;
    @(negedge clk);
    #1;
    cyc("reset", W_IDLE);
    cyc("reset", W_IDLE);
    reset = 1'b0; entry_req = 1'b0;
    cyc("idle", W_IDLE);

    // Single entry with pass in the second OPEN cycle; pass/obstruct noise while opening.
    entry_req = 1'b1;
    cyc("grant_entry", w_phase(2'b01, 1'b1, 1'b0, 1'b0));
    entry_req = 1'b0;
    up_to_open(2'b01, 1'b1);
    hold(2'b01, 2'd0, 2, 1'b1);
    close_tail(2'b01);

    // Full lot: one reject per request assertion.
    capacity = 3'd0; entry_req = 1'b1;
    for (int i = 0; i < 10; i++) cyc("full_reject", (i == 0) ? W_ER : W_IDLE);
    entry_req = 1'b0;
    cyc("drop", W_IDLE);
    entry_req = 1'b1;
    cyc("reject_again", W_ER);
    cyc("locked", W_IDLE);
    entry_req = 1'b0;
    cyc("drop", W_IDLE);

    // Exit from an empty slot.
    spots = 4'b0100; exit_slot = 2'd1; exit_req = 1'b1;
    cyc("exit_reject", W_XR);
    cyc("exit_locked", W_IDLE);
    exit_req = 1'b0;
    cyc("drop", W_IDLE);

    // Simultaneous requests after reset: exit first, then entry (which times out).
    reset = 1'b1; capacity = 3'd3; exit_slot = 2'd2; entry_req = 1'b1; exit_req = 1'b1;
    cyc("reset2", W_IDLE);
    reset = 1'b0;
    cyc("rr_exit_first", w_phase(2'b10, 1'b1, 1'b0, 1'b0));
    exit_req = 1'b0;
    up_to_open(2'b10, 1'b0);
    hold(2'b10, 2'd2, 1, 1'b1);
    close_tail(2'b10);
    cyc("entry_next", w_phase(2'b01, 1'b1, 1'b0, 1'b0));
    entry_req = 1'b0;
    up_to_open(2'b01, 1'b0);
    hold(2'b01, 2'd0, 0, 1'b0);
    close_tail(2'b01);

    // Entry reject alongside an exit grant, then obstruct reopen with no second ack.
    capacity = 3'd0; entry_req = 1'b1; exit_req = 1'b1;
    cyc("reject_and_grant", w_phase(2'b10, 1'b1, 1'b0, 1'b0) | W_ER);
    exit_req = 1'b0;
    up_to_open(2'b10, 1'b0);
    hold(2'b10, 2'd2, 1, 1'b1);
    cyc("closing2", w_phase(2'b10, 1'b0, 1'b1, 1'b0));
    obstruct = 1'b1;
    cyc("reopen", w_phase(2'b10, 1'b1, 1'b0, 1'b0));
    obstruct = 1'b0;
    up_to_open(2'b10, 1'b0);
    hold(2'b10, 2'd2, 2, 1'b0);
    close_tail(2'b10);
    entry_req = 1'b0;
    cyc("idle", W_IDLE);

    // Round robin hands the tie to entry, then reset mid-OPEN restores exit priority.
    capacity = 3'd3; entry_req = 1'b1; exit_req = 1'b1;
    cyc("rr_entry", w_phase(2'b01, 1'b1, 1'b0, 1'b0));
    up_to_open(2'b01, 1'b0);
    reset = 1'b1;
    cyc("mid_reset", W_IDLE);
    reset = 1'b0;
    cyc("post_reset_exit", w_phase(2'b10, 1'b1, 1'b0, 1'b0));
    entry_req = 1'b0; exit_req = 1'b0;
    up_to_open(2'b10, 1'b0);
    hold(2'b10, 2'd2, 3, 1'b1);
    close_tail(2'b10);
    cyc("idle_end", W_IDLE);

    check_eq("drain", 12'(exp_q.size()), 12'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
